// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the pipelined MIPS core front end.
//   - pc_state_e : program-counter sequencer states (BOOT, RUN, DRAIN)
//   - RESET_PC_DEFAULT / EXC_VEC_DEFAULT : default reset and exception vectors
//   - opcode and instruction field widths used by the decoder
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    // Sequencer states: BOOT is the single dead cycle after reset, DRAIN
    // lets the pipeline empty before vectoring to the exception handler.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h8000_0180;

    // Instruction field widths.
    localparam int XLEN       = 32;
    localparam int OPCODE_W   = 6;
    localparam int REG_W      = 5;
    localparam int SHAMT_W    = 5;
    localparam int FUNCT_W    = 6;
    localparam int IMM_W      = 16;
    localparam int JIDX_W     = 26;
    localparam int DRAIN_CNT_W = 4;

    // Opcodes the front end cares about.
    localparam logic [OPCODE_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OPC_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OPC_JAL   = 6'h03;
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OPC_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OPC_SW    = 6'h2B;

endpackage

// File: rtl/branch_target_calc.sv
// -----------------------------------------------------------------------------
// branch_target_calc
// Purely combinational redirect-target arithmetic for the PC sequencer.
//   branch_pc4    in  32 : PC+4 of the branch in EX
//   branch_imm    in  32 : sign-extended branch immediate
//   jump_pc4      in  32 : PC+4 of the jump in ID
//   jump_idx      in  26 : jump instruction index field
//   branch_target out 32 : branch_pc4 + (imm << 2), wraps modulo 2^32
//   jump_target   out 32 : {jump_pc4[31:28], jump_idx, 2'b00}
// -----------------------------------------------------------------------------
module branch_target_calc
    import mips_pkg::*;
(
    input  logic [31:0]       branch_pc4,
    input  logic [31:0]       branch_imm,
    input  logic [31:0]       jump_pc4,
    input  logic [JIDX_W-1:0] jump_idx,
    output logic [31:0]       branch_target,
    output logic [31:0]       jump_target
);

    logic [31:0] imm_words;

    // The top two immediate bits fall off the word shift; the sum wraps
    // silently, matching the architecture's lack of branch overflow traps.
    assign imm_words     = {branch_imm[29:0], 2'b00};
    assign branch_target = branch_pc4 + imm_words;

    // Jumps stay inside the current 256 MB region of the delay-slot PC.
    assign jump_target   = {jump_pc4[31:28], jump_idx, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the fetch PC. Each cycle picks between sequential fetch, a taken
// branch (EX), a jump (ID), a load-use stall and an exception redirect,
// drives the IF/ID and ID/EX flush lines, and drains the pipe for
// DRAIN_CYCLES cycles before vectoring to EXC_VEC.
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall_i           : load-use stall from the hazard unit
//   branch_i, branch_pc4_i, branch_imm_i : taken branch in EX
//   jump_i, jump_pc4_i, jump_idx_i       : J/JAL in ID
//   exc_i, exc_pc_i   : exception request and faulting PC
//   pc_o, pc_plus4_o  : fetch address and its successor
//   pc_valid_o        : pc_o is a real fetch (RUN state only)
//   flush_ifid_o, flush_idex_o : pipeline register clears (combinational)
//   epc_o             : captured exception PC
// -----------------------------------------------------------------------------
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VEC      = EXC_VEC_DEFAULT,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [31:0]       branch_pc4_i,
    input  logic [31:0]       branch_imm_i,
    input  logic              jump_i,
    input  logic [31:0]       jump_pc4_i,
    input  logic [JIDX_W-1:0] jump_idx_i,
    input  logic              exc_i,
    input  logic [31:0]       exc_pc_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_plus4_o,
    output logic              pc_valid_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic [31:0]       epc_o
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    pc_state_e              state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            epc_q, epc_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] pc_seq;

    branch_target_calc u_target (
        .branch_pc4    (branch_pc4_i),
        .branch_imm    (branch_imm_i),
        .jump_pc4      (jump_pc4_i),
        .jump_idx      (jump_idx_i),
        .branch_target (branch_target),
        .jump_target   (jump_target)
    );

    assign pc_seq = pc_q + 32'd4;

    // Next-state / next-PC selection. In RUN the order is exception,
    // branch, jump, stall, sequential: the branch beats the jump and the
    // stall because it belongs to the older instruction in EX.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (exc_i) begin
                    epc_d   = exc_pc_i;
                    cnt_d   = DRAIN_LOAD;
                    state_d = DRAIN;
                end else if (branch_i) begin
                    pc_d = branch_target;
                end else if (jump_i) begin
                    pc_d = jump_target;
                end else if (!stall_i) begin
                    pc_d = pc_seq;
                end
            end
            DRAIN: begin
                // All redirect/stall inputs are ignored while draining.
                if (cnt_q == '0) begin
                    pc_d    = EXC_VEC;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Flushes are decoded from the current state and inputs so the
    // pipeline registers are cleared on the same edge the PC redirects.
    always_comb begin
        flush_ifid_o = 1'b0;
        flush_idex_o = 1'b0;
        unique case (state_q)
            RUN: begin
                if (exc_i || branch_i) begin
                    flush_ifid_o = 1'b1;
                    flush_idex_o = 1'b1;
                end else if (jump_i) begin
                    // The jump resolves in ID, so only the wrong-path fetch dies.
                    flush_ifid_o = 1'b1;
                end
            end
            DRAIN: begin
                flush_ifid_o = 1'b1;
                flush_idex_o = 1'b1;
            end
            default: begin
                flush_ifid_o = 1'b0;
                flush_idex_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_seq;
    assign pc_valid_o = (state_q == RUN);
    assign epc_o      = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed scenarios plus a randomized run checked against a behavioural
// model of the sequencer.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC  = 32'h8000_0180;
    localparam int          DRAIN_N  = 3;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_pc4_i;
    logic [31:0] branch_imm_i;
    logic        jump_i;
    logic [31:0] jump_pc4_i;
    logic [25:0] jump_idx_i;
    logic        exc_i;
    logic [31:0] exc_pc_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        pc_valid_o;
    logic        flush_ifid_o;
    logic        flush_idex_o;
    logic [31:0] epc_o;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_sequencer #(
        .RESET_PC     (RESET_PC),
        .EXC_VEC      (EXC_VEC),
        .DRAIN_CYCLES (DRAIN_N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .branch_i     (branch_i),
        .branch_pc4_i (branch_pc4_i),
        .branch_imm_i (branch_imm_i),
        .jump_i       (jump_i),
        .jump_pc4_i   (jump_pc4_i),
        .jump_idx_i   (jump_idx_i),
        .exc_i        (exc_i),
        .exc_pc_i     (exc_pc_i),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .pc_valid_o   (pc_valid_o),
        .flush_ifid_o (flush_ifid_o),
        .flush_idex_o (flush_idex_o),
        .epc_o        (epc_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i      = 1'b0;
        branch_i     = 1'b0;
        branch_pc4_i = 32'h0;
        branch_imm_i = 32'h0;
        jump_i       = 1'b0;
        jump_pc4_i   = 32'h0;
        jump_idx_i   = 26'h0;
        exc_i        = 1'b0;
        exc_pc_i     = 32'h0;
    endtask

    // Reset, then release mid-cycle and land at posedge+1 in the BOOT cycle.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    // m_boot: dead cycle pending; m_drain_left: drain cycles still to go.
    bit          m_boot;
    int          m_drain_left;
    logic [31:0] m_pc;
    logic [31:0] m_epc;

    function automatic void model_reset();
        m_boot       = 1'b1;
        m_drain_left = 0;
        m_pc         = RESET_PC;
        m_epc        = 32'h0;
    endfunction

    function automatic void model_step();
        logic [31:0] tgt;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_drain_left > 0) begin
            m_drain_left = m_drain_left - 1;
            if (m_drain_left == 0) m_pc = EXC_VEC;
        end else if (exc_i) begin
            m_epc        = exc_pc_i;
            m_drain_left = DRAIN_N;
        end else if (branch_i) begin
            tgt  = branch_imm_i * 32'd4;
            m_pc = branch_pc4_i + tgt;
        end else if (jump_i) begin
            m_pc = (jump_pc4_i & 32'hF000_0000) | ({6'b0, jump_idx_i} * 32'd4);
        end else if (!stall_i) begin
            m_pc = m_pc + 32'd4;
        end
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8;
        clear_inputs();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if (pc_o !== RESET_PC || pc_valid_o !== 1'b0 || epc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state pc=%h valid=%b epc=%h required pc=%h valid=0 epc=0",
                     pc_o, pc_valid_o, epc_o, RESET_PC);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || flush_ifid_o !== 1'b0 || flush_idex_o !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_cycle pc=%h valid=%b fl=%b%b required pc=0 valid=0 fl=00",
                     pc_o, pc_valid_o, flush_ifid_o, flush_idex_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (pc_o !== exp_seq[i] || pc_valid_o !== 1'b1 || pc_plus4_o !== exp_seq[i] + 32'd4) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d] pc=%h p4=%h valid=%b required pc=%h valid=1",
                         i, pc_o, pc_plus4_o, pc_valid_o, exp_seq[i]);
            end
        end
    endtask

    // Starts with pc=8 in RUN.
    task automatic test_branch();
        branch_i = 1'b1; stall_i = 1'b1;
        branch_pc4_i = 32'h0000_0100; branch_imm_i = 32'hFFFF_FFFC;
        #1;
        n_cmp++;
        if (flush_ifid_o !== 1'b1 || flush_idex_o !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_flush fl=%b%b required 11", flush_ifid_o, flush_idex_o);
        end
        tick();
        clear_inputs();
        n_cmp++;
        if (pc_o !== 32'h0000_00F0) begin
            n_fail++;
            $display("FAIL branch_target pc=%h required 000000f0", pc_o);
        end
    endtask

    task automatic test_jump();
        jump_i = 1'b1; jump_pc4_i = 32'h4000_0010; jump_idx_i = 26'h000_0040;
        #1;
        n_cmp++;
        if (flush_ifid_o !== 1'b1 || flush_idex_o !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_flush fl=%b%b required 10", flush_ifid_o, flush_idex_o);
        end
        tick();
        clear_inputs();
        n_cmp++;
        if (pc_o !== 32'h4000_0100) begin
            n_fail++;
            $display("FAIL jump_target pc=%h required 40000100", pc_o);
        end
    endtask

    task automatic test_branch_jump();
        branch_i = 1'b1; branch_pc4_i = 32'h0000_1000; branch_imm_i = 32'h0000_0004;
        jump_i = 1'b1; jump_pc4_i = 32'h3000_0000; jump_idx_i = 26'h0ABCDE;
        #1;
        n_cmp++;
        if (flush_idex_o !== 1'b1) begin
            n_fail++;
            $display("FAIL br_jmp_flush idex=%b required 1", flush_idex_o);
        end
        tick();
        clear_inputs();
        n_cmp++;
        if (pc_o !== 32'h0000_1010) begin
            n_fail++;
            $display("FAIL br_over_jmp pc=%h required 00001010", pc_o);
        end
    endtask

    task automatic test_stall();
        branch_i = 1'b1; branch_pc4_i = 32'h0000_0020; branch_imm_i = 32'h0;
        tick();
        clear_inputs();
        stall_i = 1'b1;
        #1;
        n_cmp++;
        if (flush_ifid_o !== 1'b0 || flush_idex_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_flush fl=%b%b required 00", flush_ifid_o, flush_idex_o);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (pc_o !== 32'h20) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] pc=%h required 00000020", i, pc_o);
            end
            tick();
        end
        stall_i = 1'b0;
        n_cmp++;
        if (pc_o !== 32'h20) begin
            n_fail++;
            $display("FAIL stall_hold_last pc=%h required 00000020", pc_o);
        end
        tick();
        n_cmp++;
        if (pc_o !== 32'h24) begin
            n_fail++;
            $display("FAIL stall_release pc=%h required 00000024", pc_o);
        end
    endtask

    task automatic test_wrap();
        branch_i = 1'b1; branch_pc4_i = 32'h0; branch_imm_i = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        n_cmp++;
        if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_edge pc=%h p4=%h required fffffffc/00000000", pc_o, pc_plus4_o);
        end
        tick();
        n_cmp++;
        if (pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_seq pc=%h required 00000000", pc_o);
        end
    endtask

    task automatic test_exception();
        logic [31:0] held;
        held = pc_o;
        exc_i = 1'b1; exc_pc_i = 32'h0000_0048;
        #1;
        n_cmp++;
        if (flush_ifid_o !== 1'b1 || flush_idex_o !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_flush fl=%b%b required 11", flush_ifid_o, flush_idex_o);
        end
        tick();
        clear_inputs();
        n_cmp++;
        if (epc_o !== 32'h48) begin
            n_fail++;
            $display("FAIL exc_epc epc=%h required 00000048", epc_o);
        end
        for (int i = 0; i < DRAIN_N; i++) begin
            branch_i = (i == 0); branch_pc4_i = 32'h0000_0500; branch_imm_i = 32'h10;
            jump_i = (i == 1); jump_pc4_i = 32'h0; jump_idx_i = 26'h55;
            exc_i = (i == 2); exc_pc_i = 32'h0000_0999;
            #1;
            n_cmp++;
            if (pc_valid_o !== 1'b0 || flush_ifid_o !== 1'b1 || flush_idex_o !== 1'b1 || pc_o !== held) begin
                n_fail++;
                $display("FAIL drain[%0d] valid=%b fl=%b%b pc=%h required valid=0 fl=11 pc=%h",
                         i, pc_valid_o, flush_ifid_o, flush_idex_o, pc_o, held);
            end
            tick();
            clear_inputs();
        end
        n_cmp++;
        if (pc_o !== EXC_VEC || pc_valid_o !== 1'b1 || epc_o !== 32'h48) begin
            n_fail++;
            $display("FAIL exc_vector pc=%h valid=%b epc=%h required %h valid=1 epc=00000048",
                     pc_o, pc_valid_o, epc_o, EXC_VEC);
        end
    endtask

    task automatic test_reset_mid_drain();
        exc_i = 1'b1; exc_pc_i = 32'h0000_0abc;
        tick();
        clear_inputs();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pc_o !== RESET_PC || epc_o !== 32'h0 || pc_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_drain pc=%h epc=%h valid=%b required pc=%h epc=0 valid=0",
                     pc_o, epc_o, pc_valid_o, RESET_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (pc_o !== RESET_PC || pc_valid_o !== 1'b1 || flush_idex_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_run pc=%h valid=%b idex=%b required pc=%h valid=1 idex=0",
                     pc_o, pc_valid_o, flush_idex_o, RESET_PC);
        end
    endtask

    task automatic test_random();
        bit          e_valid, e_ifid, e_idex, running;
        int          fails_here;
        fails_here = 0;
        do_reset();
        model_reset();
        #1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            stall_i      = ($urandom_range(0, 3) == 0);
            branch_i     = ($urandom_range(0, 5) == 0);
            branch_pc4_i = $urandom;
            branch_imm_i = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
            jump_i       = ($urandom_range(0, 5) == 0);
            jump_pc4_i   = $urandom;
            jump_idx_i   = 26'($urandom);
            exc_i        = ($urandom_range(0, 15) == 0);
            exc_pc_i     = $urandom;
            #1;
            running = !m_boot && (m_drain_left == 0);
            e_valid = running;
            e_ifid  = (m_drain_left > 0) || (running && (exc_i || branch_i || jump_i));
            e_idex  = (m_drain_left > 0) || (running && (exc_i || branch_i));
            n_cmp++;
            if (pc_o !== m_pc || pc_plus4_o !== m_pc + 32'd4 || pc_valid_o !== e_valid ||
                epc_o !== m_epc || flush_ifid_o !== e_ifid || flush_idex_o !== e_idex) begin
                n_fail++;
                fails_here++;
                if (fails_here <= 5)
                    $display("FAIL random[%0d] pc=%h p4=%h v=%b epc=%h fl=%b%b required pc=%h v=%b epc=%h fl=%b%b",
                             cyc, pc_o, pc_plus4_o, pc_valid_o, epc_o, flush_ifid_o, flush_idex_o,
                             m_pc, e_valid, m_epc, e_ifid, e_idex);
            end
            model_step();
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_branch();
        test_jump();
        test_branch_jump();
        test_stall();
        test_wrap();
        test_exception();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the pipelined MIPS core. It owns the PC register and chooses each cycle between sequential fetch, a taken branch resolved in EX, a jump decoded in ID, a load-use stall and an exception redirect. It drives the IF/ID and ID/EX flush lines and runs a short drain FSM on exceptions before vectoring. It sits at the front of the IF stage, between the hazard unit and instruction memory.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `EXC_VEC`, default 32'h8000_0180: exception handler address.
- `DRAIN_CYCLES`, default 3: drain length in cycles; legal range 1..15.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `stall_i`, in, 1: load-use stall request from the hazard unit.
- `branch_i`, in, 1: branch in EX resolved taken.
- `branch_pc4_i`, in, 32: PC+4 of the branch in EX.
- `branch_imm_i`, in, 32: sign-extended immediate of the branch in EX.
- `jump_i`, in, 1: J/JAL decoded in ID.
- `jump_pc4_i`, in, 32: PC+4 of the jump in ID.
- `jump_idx_i`, in, 26: jump instruction index field.
- `exc_i`, in, 1: exception request.
- `exc_pc_i`, in, 32: PC of the faulting instruction.
- `pc_o`, out, 32: fetch address.
- `pc_plus4_o`, out, 32: `pc_o` + 4, modulo 2^32.
- `pc_valid_o`, out, 1: `pc_o` is a real fetch.
- `flush_ifid_o`, out, 1: clear the IF/ID register.
- `flush_idex_o`, out, 1: clear the ID/EX register.
- `epc_o`, out, 32: captured exception PC.

## Operation
- FSM states: BOOT, RUN, DRAIN.
- Reset: state = BOOT, `pc_o` = RESET_PC, `epc_o` = 0, drain count = 0.
- BOOT: `pc_valid_o` = 0, both flushes = 0. Moves to RUN unconditionally on the next edge. PC is unchanged.
- In RUN, `pc_valid_o` = 1. Priority is highest first:
  - `exc_i`: `epc_o` <= `exc_pc_i`, count <= DRAIN_CYCLES-1, state <= DRAIN, PC held. Both flushes = 1 in the same cycle.
  - `branch_i`: PC <= `branch_pc4_i` + {`branch_imm_i`[29:0], 2'b00}, 32-bit wrap with no overflow detection. Both flushes = 1 in the same cycle.
  - `jump_i`: PC <= {`jump_pc4_i`[31:28], `jump_idx_i`, 2'b00}. `flush_ifid_o` = 1 and `flush_idex_o` = 0.
  - `stall_i`: PC held, both flushes = 0.
  - Otherwise: PC <= PC + 4.
- A branch overrides both a stall and a jump in the same cycle, because the branch is the older instruction.
- DRAIN:
  - `pc_valid_o` = 0, both flushes held at 1.
  - `branch_i`, `jump_i`, `stall_i` and `exc_i` are all ignored.
  - When count = 0 at an edge, PC <= EXC_VEC and state <= RUN. Otherwise count decrements.
- Flush outputs are combinational from the current state and inputs. `pc_o`, `epc_o` and `pc_valid_o` are registered or state-decoded only.
- Asserting `rst_n` mid-DRAIN or mid-redirect aborts immediately to the reset values. No partial update survives.

## Timing
- Redirect latency is 1 cycle: `branch_i` or `jump_i` sampled at edge N gives the new `pc_o` after edge N.
- Exception: `exc_i` sampled at edge N gives DRAIN for exactly DRAIN_CYCLES cycles. Then `pc_o` = EXC_VEC with `pc_valid_o` = 1 after edge N+DRAIN_CYCLES.
- Stall: `pc_o` holds its value for as many consecutive cycles as `stall_i` stays high, with no limit.
- First valid fetch is at RESET_PC, in the second cycle after `rst_n` deasserts.
- `pc_plus4_o` tracks `pc_o` in the same cycle. 32'hFFFF_FFFC + 4 = 0.

## Structure
- The shared package `mips_pkg` holds:
  - the state enum: BOOT, RUN, DRAIN;
  - default constants for RESET_PC and EXC_VEC;
  - the opcode/field-width constants used by the decoder.
- Sub-module `branch_target_calc` holds the target arithmetic: word shift of the immediate plus the adder, and jump-target concatenation. It is purely combinational.
- The FSM, drain counter (4 bits), PC register and EPC register all stay in the top level.

## Test plan
- Reset release: `pc_o` = 0, `pc_valid_o` = 0 for one cycle. Then 0, 4, 8 with `pc_valid_o` = 1.
- Branch: `branch_pc4_i` = 32'h0000_0100, `branch_imm_i` = 32'hFFFF_FFFC, `branch_i` pulsed together with `stall_i` → next `pc_o` = 32'h0000_00F0. Both flushes are high in that cycle.
- Jump: `jump_pc4_i` = 32'h4000_0010, `jump_idx_i` = 26'h000_0040 → `pc_o` = 32'h4000_0100. Only `flush_ifid_o` is high.
- Branch and jump in the same cycle: branch target wins.
- Stall for 3 cycles at `pc_o` = 32'h20: `pc_o` holds at 32'h20, then advances to 32'h24.
- Exception at `exc_pc_i` = 32'h0000_0048 with DRAIN_CYCLES = 3:
  - `epc_o` = 32'h48.
  - Three cycles with `pc_valid_o` = 0 and both flushes high; a `branch_i` pulse during them is ignored.
  - Then `pc_o` = 32'h8000_0180.
- Reset mid-DRAIN: `pc_o` returns to RESET_PC and `epc_o` = 0, asynchronously and before the next edge.
